// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and load-use interlock for an in-order
// pipeline. It keeps one destination tag per in-flight stage after ID
// (stage 0 = EX ... stage DEPTH-1 = WB). Each ID source register is matched
// against these tags, youngest stage first. The result is either a value
// forwarded from a stage, the register-file value, or a stall request when
// the matching producer has not yet computed its result.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   pipe_adv     every stage advances this cycle
//   flush        kill the FLUSH_STAGES youngest stages
//   issue_valid  ID presents an instruction
//   issue_rd     destination register of the issuing instruction
//   issue_rdy    first stage index in which that result exists
//   src_addr     flattened source register numbers, 5 bits per source
//   gr_data      flattened register-file read data, XLEN per source
//   stage_data   flattened result value held in each stage, XLEN per stage
//   src_data     resolved operand values (combinational)
//   fwd_sel      per source: 0 = register file, i+1 = stage i (combinational)
//   stall        ID must hold because an operand is not produced yet (combinational)
//   stall_cnt    saturating count of counted stall cycles (registered)
module fwd_scoreboard #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NSRC         = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_STAGES = 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           pipe_adv,
  input  logic                                           flush,
  input  logic                                           issue_valid,
  input  logic [4:0]                                     issue_rd,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]   issue_rdy,
  input  logic [5*NSRC-1:0]                              src_addr,
  input  logic [XLEN*NSRC-1:0]                           gr_data,
  input  logic [XLEN*DEPTH-1:0]                          stage_data,
  output logic [XLEN*NSRC-1:0]                           src_data,
  output logic [$clog2(DEPTH+1)*NSRC-1:0]                fwd_sel,
  output logic                                           stall,
  output logic [15:0]                                    stall_cnt
);

  localparam int unsigned RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam int unsigned CW = 16;

  // Tag entry per in-flight stage
  logic          r_vld [DEPTH];
  logic [4:0]    r_rd  [DEPTH];
  logic [RW-1:0] r_rdy [DEPTH];
  logic [CW-1:0] r_stall_cnt;

  // Per-source resolution results
  logic [XLEN-1:0] w_data [NSRC];
  logic [SW-1:0]   w_sel  [NSRC];
  logic            w_hold [NSRC];
  logic            w_hit  [NSRC];
  logic            w_stall;
  logic            w_load_vld;

  // Youngest-first tag match; the first hit decides, so a not-yet-ready
  // young producer blocks any older ready copy of the same register.
  always_comb begin
    for (int s = 0; s < int'(NSRC); s++) begin
      w_data[s] = gr_data[s*XLEN +: XLEN];
      w_sel[s]  = '0;
      w_hold[s] = 1'b0;
      w_hit[s]  = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!w_hit[s] && r_vld[i] && (src_addr[s*5 +: 5] != 5'd0) &&
            (r_rd[i] == src_addr[s*5 +: 5])) begin
          w_hit[s] = 1'b1;
          if (r_rdy[i] <= RW'(i)) begin
            w_data[s] = stage_data[i*XLEN +: XLEN];
            w_sel[s]  = SW'(i + 1);
          end else begin
            w_hold[s] = 1'b1;
          end
        end
      end
    end
  end

  // Any blocked source holds ID
  always_comb begin
    w_stall = 1'b0;
    for (int s = 0; s < int'(NSRC); s++) begin
      w_stall = w_stall | w_hold[s];
    end
  end

  // A stalled or rd=0 issue enters stage 0 as a bubble
  assign w_load_vld = issue_valid & ~w_stall & (issue_rd != 5'd0);

  // Tag pipeline: shift on pipe_adv, then flush overrides the youngest stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_vld[i] <= 1'b0;
        r_rd[i]  <= 5'd0;
        r_rdy[i] <= '0;
      end
    end else begin
      if (pipe_adv) begin
        for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
          r_vld[i] <= r_vld[i-1];
          r_rd[i]  <= r_rd[i-1];
          r_rdy[i] <= r_rdy[i-1];
        end
        r_vld[0] <= w_load_vld;
        r_rd[0]  <= issue_rd;
        r_rdy[0] <= issue_rdy;
      end
      if (flush) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (i < int'(FLUSH_STAGES)) begin
            r_vld[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Stall cycle counter; flushed cycles are not counted, saturates at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !flush && (r_stall_cnt != {CW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  // Flatten per-source results onto the output buses
  for (genvar s = 0; s < int'(NSRC); s++) begin : g_out
    assign src_data[s*XLEN +: XLEN] = w_data[s];
    assign fwd_sel[s*SW +: SW]      = w_sel[s];
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (default parameters). Stimulus pushes the
// hand-computed expected outputs into a queue; a monitor pops them on the
// falling edge of the same cycle and compares against the DUT.
module tb_fwd_scoreboard;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        pipe_adv;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_rdy;
  logic [9:0]  src_addr;
  logic [63:0] gr_data;
  logic [127:0] stage_data;
  logic [63:0] src_data;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  logic [4:0]  a0, a1;
  logic [31:0] g0, g1;
  logic [31:0] sd [DEPTH];

  assign src_addr   = {a1, a0};
  assign gr_data    = {g1, g0};
  assign stage_data = {sd[3], sd[2], sd[1], sd[0]};

  fwd_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .FLUSH_STAGES(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_adv   (pipe_adv),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_rdy  (issue_rdy),
    .src_addr   (src_addr),
    .gr_data    (gr_data),
    .stage_data (stage_data),
    .src_data   (src_data),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [2:0]  s0;
    logic [31:0] d1;
    logic [2:0]  s1;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whenever one is expected
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, ".src_data0"}, src_data[31:0],  e.d0);
      cmp({e.name, ".fwd_sel0"},  32'(fwd_sel[2:0]), 32'(e.s0));
      cmp({e.name, ".src_data1"}, src_data[63:32], e.d1);
      cmp({e.name, ".fwd_sel1"},  32'(fwd_sel[5:3]), 32'(e.s1));
      cmp({e.name, ".stall"},     32'(stall),      32'(e.st));
      cmp({e.name, ".stall_cnt"}, 32'(stall_cnt),  32'(e.cnt));
    end
  end

  task automatic expect_out(input string name, input logic [31:0] d0, input logic [2:0] s0,
                            input logic [31:0] d1, input logic [2:0] s1,
                            input logic st, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.d0 = d0; e.s0 = s0; e.d1 = d1; e.s1 = s1; e.st = st; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] rdy);
    issue_valid = 1'b1; issue_rd = rd; issue_rdy = rdy; pipe_adv = 1'b1;
    tick();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_rdy = 2'd0;
  endtask

  task automatic drain();
    a0 = 5'd0; a1 = 5'd0; issue_valid = 1'b0; pipe_adv = 1'b1; flush = 1'b0;
    repeat (DEPTH) tick();
    pipe_adv = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pipe_adv = 1'b1; flush = 1'b0; issue_valid = 1'b1;
    issue_rd = 5'd5; issue_rdy = 2'd0; a0 = 5'd5; a1 = 5'd6;
    g0 = 32'hAAAA_0000; g1 = 32'hBBBB_0001;
    sd[0] = 32'h0000_1234; sd[1] = 32'h1111_0001; sd[2] = 32'h2222_0002; sd[3] = 32'h3333_0003;

    // Reset overrides issue/adv; no entries -> register-file path
    tick(); tick();
    expect_out("reset", g0, 3'd0, g1, 3'd0, 1'b0, 16'd0);
    tick();
    reset = 1'b0; issue_valid = 1'b0; pipe_adv = 1'b0; a0 = 5'd0; a1 = 5'd0;

    // ALU result forwarded from stage 0
    issue(5'd5, 2'd0);
    pipe_adv = 1'b0; a0 = 5'd5; a1 = 5'd6;
    expect_out("alu_fwd", 32'h0000_1234, 3'd1, g1, 3'd0, 1'b0, 16'd0);
    tick();
    drain();

    // Load-use: two stall cycles with bubbles, then forward from stage 2
    issue(5'd7, 2'd2);
    a0 = 5'd7; pipe_adv = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8; issue_rdy = 2'd0;
    expect_out("load_st0", g0, 3'd0, g1, 3'd0, 1'b1, 16'd0);
    tick();
    expect_out("load_st1", g0, 3'd0, g1, 3'd0, 1'b1, 16'd1);
    tick();
    a1 = 5'd8;  // r8 was offered during stall; stages 0/1 must hold bubbles
    expect_out("load_fwd", 32'h2222_0002, 3'd3, g1, 3'd0, 1'b0, 16'd2);
    tick();
    issue_valid = 1'b0;
    drain();

    // Same rd in stage 0 and stage 2: youngest wins
    issue(5'd3, 2'd0);
    issue(5'd4, 2'd0);
    issue(5'd3, 2'd0);
    pipe_adv = 1'b0; a0 = 5'd3; a1 = 5'd4;
    sd[0] = 32'hA0A0_A0A0; sd[1] = 32'hC4C4_C4C4; sd[2] = 32'hB0B0_B0B0;
    expect_out("youngest", 32'hA0A0_A0A0, 3'd1, 32'hC4C4_C4C4, 3'd2, 1'b0, 16'd2);
    tick();
    drain();

    // rd=0 is never tracked and r0 never matches
    issue(5'd0, 2'd0);
    pipe_adv = 1'b0; a0 = 5'd0; g0 = 32'd0; sd[0] = 32'hDEAD_BEEF;
    expect_out("r0", 32'd0, 3'd0, g1, 3'd0, 1'b0, 16'd2);
    tick();
    g0 = 32'hAAAA_0000;
    drain();

    // Flush kills stage 0 without advancing; stage 1 stays; flushed stall not counted
    sd[1] = 32'h1111_0001;
    issue(5'd11, 2'd0);
    issue(5'd9, 2'd2);
    pipe_adv = 1'b0; flush = 1'b1; a0 = 5'd9;
    expect_out("flush_cyc", g0, 3'd0, g1, 3'd0, 1'b1, 16'd2);
    tick();
    flush = 1'b0; a1 = 5'd11;
    expect_out("post_flush", g0, 3'd0, 32'h1111_0001, 3'd2, 1'b0, 16'd2);
    tick();
    drain();

    // Long stall saturates the counter, then reset clears it
    issue(5'd7, 2'd2);
    pipe_adv = 1'b0; a0 = 5'd7;
    repeat (70000) tick();
    expect_out("sat", g0, 3'd0, g1, 3'd0, 1'b1, 16'hFFFF);
    tick();
    expect_out("sat_hold", g0, 3'd0, g1, 3'd0, 1'b1, 16'hFFFF);
    tick();
    reset = 1'b1;
    tick();
    expect_out("reset_mid", g0, 3'd0, g1, 3'd0, 1'b0, 16'd0);
    tick();
    reset = 1'b0;
    tick();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_empty: actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand data width.
REQ-002 SHALL have parameter NSRC, default 2, number of source-operand read ports.
REQ-003 SHALL have parameter DEPTH, default 4, in-flight stages after ID (0=EX,1=MM1,2=MM2,3=WB).
REQ-004 SHALL have parameter FLUSH_STAGES, default 1, count of youngest stages killed by flush.
REQ-005 SHALL use one clock; reset is synchronous and active-high: port clk input 1 (rising-edge clock), port reset input 1 (synchronous active-high reset).
REQ-006 SHALL have port pipe_adv input 1, all stages advance this cycle.
REQ-007 SHALL have port flush input 1, kill wrong-path entries.
REQ-008 SHALL have port issue_valid input 1, ID presents an instruction.
REQ-009 SHALL have port issue_rd input 5, destination register of issuing instruction.
REQ-010 SHALL have port issue_rdy input clog2(DEPTH), first stage index where its result exists (ALU=0, load=2).
REQ-011 SHALL have port src_addr input 5*NSRC, flattened source register numbers.
REQ-012 SHALL have port gr_data input XLEN*NSRC, register-file read data.
REQ-013 SHALL have port stage_data input XLEN*DEPTH, result value currently held in each stage.
REQ-014 SHALL have port src_data output XLEN*NSRC, resolved operand values.
REQ-015 SHALL have port fwd_sel output clog2(DEPTH+1)*NSRC, per source: 0=register file, i+1=stage i.
REQ-016 SHALL have port stall output 1, ID must hold; operand not yet produced.
REQ-017 SHALL have port stall_cnt output 16, saturating count of stall cycles.

Function
REQ-018 SHALL hold per stage a tag entry {valid, rd, rdy}; entry valid only if issued with issue_rd != 0.
REQ-019 SHALL, per source, match src_addr against valid entries youngest-first (stage 0 first); first match wins; src_addr 0 never matches.
REQ-020 SHALL, on first match in stage i with i >= rdy, drive src_data = stage_data[i], fwd_sel = i+1.
REQ-021 SHALL, on first match in stage i with i < rdy, assert stall; an older ready match SHALL NOT override it.
REQ-022 SHALL, with no match, drive src_data = gr_data, fwd_sel = 0.
REQ-023 SHALL compute src_data, fwd_sel, stall combinationally (zero latency); stall is the OR over all sources.
REQ-024 SHALL, when pipe_adv=1, shift entry i-1 into stage i for i>=1; stage 0 loads {issue_valid & !stall & issue_rd!=0, issue_rd, issue_rdy}, else a bubble; entry in stage DEPTH-1 retires.
REQ-025 SHALL, when pipe_adv=0, hold all entries unchanged.
REQ-026 SHALL, when flush=1, invalidate stages 0..FLUSH_STAGES-1 next cycle regardless of pipe_adv or issue; stages >= FLUSH_STAGES shift per REQ-024/025 (stage FLUSH_STAGES receives pre-flush entry FLUSH_STAGES-1 when pipe_adv).
REQ-027 SHALL increment stall_cnt each cycle stall=1 and flush=0; saturate at 16'hFFFF, no wrap.
REQ-028 SHALL treat simultaneous stall and pipe_adv as bubble insertion into stage 0 with older stages advancing.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, clear all entries to invalid and stall_cnt to 0; reset overrides pipe_adv, flush, issue.
REQ-030 SHALL, during and after reset with no valid entries, present src_data=gr_data, fwd_sel=0, stall=0.

Verification
REQ-031 SHALL cover: issue rd=5 rdy=0, adv; next cycle src_addr[0]=5, stage_data[0]=0x1234 -> src_data[0]=0x1234, fwd_sel=1, stall=0.
REQ-032 SHALL cover: issue load rd=7 rdy=2, adv; read r7 -> stall=1 two cycles, stage 0 bubbles; at stage 2 -> fwd_sel=3, stall=0, stall_cnt=2.
REQ-033 SHALL cover: rd=3 in stage 0 (value A) and stage 2 (value B), read r3 -> src_data=A, fwd_sel=1.
REQ-034 SHALL cover: issue rd=0 then read r0 with gr_data=0 -> fwd_sel=0, src_data=0, no stall.
REQ-035 SHALL cover: load rd=9 in stage 0, flush=1 with pipe_adv=0 -> next cycle stage 0 invalid, read r9 -> fwd_sel=0, stall=0; older stages unchanged.
REQ-036 SHALL cover: stall held 70000 cycles -> stall_cnt=0xFFFF; assert reset mid-stall -> next cycle stall_cnt=0, stall=0.
